// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard-unit command encoding, result-select codes
// and the decode->execute control bundle with its bubble constant.
package pipeline_pkg;

  typedef enum logic [1:0] {
    CONTINUE = 2'b00,
    STALL    = 2'b01,
    FLUSH    = 2'b10
  } pipeline_control;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
  } de_ctrl_t;

  localparam de_ctrl_t DE_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: captures on CONTINUE, holds on STALL and loads
// BUBBLE_VALUE on FLUSH or on any unencoded command. Synchronous reset to 0.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  pipeline_control  control_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else begin
      unique case (control_i)
        CONTINUE: q_o <= d_i;
        STALL:    q_o <= q_o;
        default:  q_o <= BUBBLE_VALUE;  // unencoded commands fail safe to a bubble
      endcase
    end
  end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register of the RV32I core. Optional performance
// counters are enabled by defining PIPE_PERF_COUNTERS_EN.
module decode_execute_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  pipeline_control           control_i,
  input  logic [DATA_WIDTH-1:0]     pc_d_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_d_i,
  input  logic [DATA_WIDTH-1:0]     rd1_d_i,
  input  logic [DATA_WIDTH-1:0]     rd2_d_i,
  input  logic [DATA_WIDTH-1:0]     imm_d_i,
  input  logic [ADDR_WIDTH-1:0]     rs1_d_i,
  input  logic [ADDR_WIDTH-1:0]     rs2_d_i,
  input  logic [ADDR_WIDTH-1:0]     rd_d_i,
  input  logic                      reg_write_d_i,
  input  logic                      mem_write_d_i,
  input  logic                      jump_d_i,
  input  logic                      branch_d_i,
  input  logic                      alu_src_d_i,
  input  logic [1:0]                result_src_d_i,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control_d_i,
  input  logic                      valid_d_i,
  output logic [DATA_WIDTH-1:0]     pc_e_o,
  output logic [DATA_WIDTH-1:0]     pc_plus4_e_o,
  output logic [DATA_WIDTH-1:0]     rd1_e_o,
  output logic [DATA_WIDTH-1:0]     rd2_e_o,
  output logic [DATA_WIDTH-1:0]     imm_e_o,
  output logic [ADDR_WIDTH-1:0]     rs1_e_o,
  output logic [ADDR_WIDTH-1:0]     rs2_e_o,
  output logic [ADDR_WIDTH-1:0]     rd_e_o,
  output logic                      reg_write_e_o,
  output logic                      mem_write_e_o,
  output logic                      jump_e_o,
  output logic                      branch_e_o,
  output logic                      alu_src_e_o,
  output logic [1:0]                result_src_e_o,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control_e_o,
  output logic                      valid_e_o,
  output logic                      is_load_e_o
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o,
  output logic [31:0]               issue_cnt_o
`endif
);

  localparam int DATA_BUNDLE_W = 5*DATA_WIDTH + 3*ADDR_WIDTH + ALU_CTRL_WIDTH;

  de_ctrl_t                 ctrl_d, ctrl_q;
  logic [DATA_BUNDLE_W-1:0] data_d, data_q;

  // Side-effect controls are masked by valid so later stages can ignore it.
  always_comb begin
    ctrl_d            = DE_CTRL_BUBBLE;
    ctrl_d.valid      = valid_d_i;
    ctrl_d.reg_write  = reg_write_d_i & valid_d_i;
    ctrl_d.mem_write  = mem_write_d_i & valid_d_i;
    ctrl_d.jump       = jump_d_i & valid_d_i;
    ctrl_d.branch     = branch_d_i & valid_d_i;
    ctrl_d.alu_src    = alu_src_d_i;
    ctrl_d.result_src = result_src_d_i;
  end

  assign data_d = {pc_d_i, pc_plus4_d_i, rd1_d_i, rd2_d_i, imm_d_i,
                   rs1_d_i, rs2_d_i, rd_d_i, alu_control_d_i};

  pipe_stage_reg #(
    .WIDTH        ($bits(de_ctrl_t)),
    .BUBBLE_VALUE (DE_CTRL_BUBBLE)
  ) u_ctrl_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .control_i (control_i),
    .d_i       (ctrl_d),
    .q_o       (ctrl_q)
  );

  // Data fields are zeroed on a bubble too; addresses must not match x0 forwarding.
  pipe_stage_reg #(
    .WIDTH        (DATA_BUNDLE_W),
    .BUBBLE_VALUE ('0)
  ) u_data_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .control_i (control_i),
    .d_i       (data_d),
    .q_o       (data_q)
  );

  assign {pc_e_o, pc_plus4_e_o, rd1_e_o, rd2_e_o, imm_e_o,
          rs1_e_o, rs2_e_o, rd_e_o, alu_control_e_o} = data_q;

  assign valid_e_o      = ctrl_q.valid;
  assign reg_write_e_o  = ctrl_q.reg_write;
  assign mem_write_e_o  = ctrl_q.mem_write;
  assign jump_e_o       = ctrl_q.jump;
  assign branch_e_o     = ctrl_q.branch;
  assign alu_src_e_o    = ctrl_q.alu_src;
  assign result_src_e_o = ctrl_q.result_src;
  assign is_load_e_o    = ctrl_q.valid & (ctrl_q.result_src == RES_MEM);

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, issue_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      unique case (control_i)
        CONTINUE: if (valid_d_i && (issue_cnt_q != '1)) issue_cnt_q <= issue_cnt_q + 32'd1;
        STALL:    if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        default:  if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      endcase
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign issue_cnt_o = issue_cnt_q;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg: a table of per-cycle vectors with
// hand-computed expectations plus sequences for reset, timing and counters.
module tb_decode_execute_reg;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  pipeline_control ctrl;
  logic [31:0] pc_d, pc4_d, rd1_d, rd2_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        rw_d, mw_d, jmp_d, br_d, asrc_d, v_d;
  logic [1:0]  rs_d;
  logic [3:0]  alu_d;
  logic [31:0] pc_e, pc4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        rw_e, mw_e, jmp_e, br_e, asrc_e, v_e, load_e;
  logic [1:0]  rs_e;
  logic [3:0]  alu_e;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt, flush_cnt, issue_cnt;
`endif

  decode_execute_reg dut (
    .clk_i(clk), .rst_i(rst), .control_i(ctrl),
    .pc_d_i(pc_d), .pc_plus4_d_i(pc4_d), .rd1_d_i(rd1_d), .rd2_d_i(rd2_d),
    .imm_d_i(imm_d), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rd_d_i(rd_d),
    .reg_write_d_i(rw_d), .mem_write_d_i(mw_d), .jump_d_i(jmp_d),
    .branch_d_i(br_d), .alu_src_d_i(asrc_d), .result_src_d_i(rs_d),
    .alu_control_d_i(alu_d), .valid_d_i(v_d),
    .pc_e_o(pc_e), .pc_plus4_e_o(pc4_e), .rd1_e_o(rd1_e), .rd2_e_o(rd2_e),
    .imm_e_o(imm_e), .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e),
    .reg_write_e_o(rw_e), .mem_write_e_o(mw_e), .jump_e_o(jmp_e),
    .branch_e_o(br_e), .alu_src_e_o(asrc_e), .result_src_e_o(rs_e),
    .alu_control_e_o(alu_e), .valid_e_o(v_e), .is_load_e_o(load_e)
`ifdef PIPE_PERF_COUNTERS_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .issue_cnt_o(issue_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // flags are {reg_write, mem_write, jump, branch}
  typedef struct {
    string       nm;
    logic        rst;
    logic [1:0]  c;
    logic [31:0] pc, rd1;
    logic [4:0]  rd;
    logic [3:0]  fl;
    logic [1:0]  rs;
    logic        v;
    logic [31:0] e_pc, e_rd1;
    logic [4:0]  e_rd;
    logic [3:0]  e_fl;
    logic [1:0]  e_rs;
    logic        e_v, e_load, e_bub;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic [1:0] c, logic [31:0] pc, rd1,
                              logic [4:0] rd, logic [3:0] fl, logic [1:0] rs, logic v,
                              logic [31:0] epc, erd1, logic [4:0] erd, logic [3:0] efl,
                              logic [1:0] ers, logic ev, logic el, logic eb);
    vec_t x;
    x.nm = nm; x.rst = r; x.c = c; x.pc = pc; x.rd1 = rd1; x.rd = rd; x.fl = fl;
    x.rs = rs; x.v = v; x.e_pc = epc; x.e_rd1 = erd1; x.e_rd = erd; x.e_fl = efl;
    x.e_rs = ers; x.e_v = ev; x.e_load = el; x.e_bub = eb;
    return x;
  endfunction

  // Secondary fields are derived from pc/rd1/rd so every bit gets exercised.
  task automatic drive(input vec_t x);
    rst    = x.rst;
    ctrl   = pipeline_control'(x.c);
    pc_d   = x.pc;
    pc4_d  = x.pc + 32'd4;
    rd1_d  = x.rd1;
    rd2_d  = ~x.rd1;
    imm_d  = x.rd1 ^ 32'h5555_5555;
    rd_d   = x.rd;
    rs1_d  = x.rd + 5'd1;
    rs2_d  = x.rd + 5'd2;
    alu_d  = x.rd[3:0];
    asrc_d = x.rd[0];
    {rw_d, mw_d, jmp_d, br_d} = x.fl;
    rs_d   = x.rs;
    v_d    = x.v;
  endtask

  task automatic check_vec(input vec_t x);
    chk({x.nm, ".pc"},      pc_e,  x.e_pc);
    chk({x.nm, ".rd1"},     rd1_e, x.e_rd1);
    chk({x.nm, ".rd"},      32'(rd_e), 32'(x.e_rd));
    chk({x.nm, ".flags"},   32'({rw_e, mw_e, jmp_e, br_e}), 32'(x.e_fl));
    chk({x.nm, ".res_src"}, 32'(rs_e), 32'(x.e_rs));
    chk({x.nm, ".valid"},   32'(v_e), 32'(x.e_v));
    chk({x.nm, ".is_load"}, 32'(load_e), 32'(x.e_load));
    if (x.e_bub) begin
      chk({x.nm, ".pc4"},  pc4_e, 32'd0);
      chk({x.nm, ".rd2"},  rd2_e, 32'd0);
      chk({x.nm, ".imm"},  imm_e, 32'd0);
      chk({x.nm, ".rs12"}, 32'({rs1_e, rs2_e}), 32'd0);
      chk({x.nm, ".alu"},  32'({alu_e, asrc_e}), 32'd0);
    end else begin
      chk({x.nm, ".pc4"},  pc4_e, x.e_pc + 32'd4);
      chk({x.nm, ".rd2"},  rd2_e, ~x.e_rd1);
      chk({x.nm, ".imm"},  imm_e, x.e_rd1 ^ 32'h5555_5555);
      chk({x.nm, ".rs1"},  32'(rs1_e), 32'(5'(x.e_rd + 5'd1)));
      chk({x.nm, ".rs2"},  32'(rs2_e), 32'(5'(x.e_rd + 5'd2)));
      chk({x.nm, ".alu"},  32'({alu_e, asrc_e}), 32'({x.e_rd[3:0], x.e_rd[0]}));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // CONTINUE=00 STALL=01 FLUSH=10, 11 unencoded
    vecs.push_back(mk("cont_pc100", 0, 2'b00, 32'h100, 32'h1, 3, 4'b1000, 2'b00, 1,
                      32'h100, 32'h1, 3, 4'b1000, 2'b00, 1, 0, 0));
    vecs.push_back(mk("cap_beef", 0, 2'b00, 32'h104, 32'hDEAD_BEEF, 7, 4'b1000, 2'b00, 1,
                      32'h104, 32'hDEAD_BEEF, 7, 4'b1000, 2'b00, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("stall", 0, 2'b01, 32'h108, 32'h1234, 9, 4'b1000, 2'b00, 1,
                        32'h104, 32'hDEAD_BEEF, 7, 4'b1000, 2'b00, 1, 0, 0));
    vecs.push_back(mk("resume", 0, 2'b00, 32'h108, 32'h1234, 9, 4'b1000, 2'b00, 1,
                      32'h108, 32'h1234, 9, 4'b1000, 2'b00, 1, 0, 0));
    vecs.push_back(mk("load_cap", 0, 2'b00, 32'h10C, 32'hAAAA, 5, 4'b1000, 2'b01, 1,
                      32'h10C, 32'hAAAA, 5, 4'b1000, 2'b01, 1, 1, 0));
    vecs.push_back(mk("flush", 0, 2'b10, 32'h110, 32'hBBBB, 8, 4'b1111, 2'b01, 1,
                      32'h0, 32'h0, 0, 4'b0000, 2'b00, 0, 0, 1));
    vecs.push_back(mk("load_mw", 0, 2'b00, 32'h114, 32'h77, 6, 4'b0100, 2'b01, 1,
                      32'h114, 32'h77, 6, 4'b0100, 2'b01, 1, 1, 0));
    vecs.push_back(mk("invalid", 0, 2'b00, 32'h114, 32'h77, 6, 4'b1111, 2'b01, 0,
                      32'h114, 32'h77, 6, 4'b0000, 2'b01, 0, 0, 0));
    vecs.push_back(mk("jmp_br", 0, 2'b00, 32'h118, 32'h99, 10, 4'b0011, 2'b10, 1,
                      32'h118, 32'h99, 10, 4'b0011, 2'b10, 1, 0, 0));
    vecs.push_back(mk("illegal", 0, 2'b11, 32'h11C, 32'h12, 11, 4'b1000, 2'b01, 1,
                      32'h0, 32'h0, 0, 4'b0000, 2'b00, 0, 0, 1));
    vecs.push_back(mk("rst_cont", 1, 2'b00, 32'h200, 32'h13, 12, 4'b1111, 2'b01, 1,
                      32'h0, 32'h0, 0, 4'b0000, 2'b00, 0, 0, 1));
    vecs.push_back(mk("post_rst", 0, 2'b00, 32'h100, 32'h14, 13, 4'b1000, 2'b00, 1,
                      32'h100, 32'h14, 13, 4'b1000, 2'b00, 1, 0, 0));
    vecs.push_back(mk("stall_hold", 0, 2'b01, 32'h204, 32'h15, 14, 4'b1000, 2'b01, 1,
                      32'h100, 32'h14, 13, 4'b1000, 2'b00, 1, 0, 0));
    vecs.push_back(mk("rst_stall", 1, 2'b01, 32'h204, 32'h15, 14, 4'b1000, 2'b01, 1,
                      32'h0, 32'h0, 0, 4'b0000, 2'b00, 0, 0, 1));
    vecs.push_back(mk("stall_empty", 0, 2'b01, 32'h208, 32'h16, 15, 4'b1000, 2'b01, 1,
                      32'h0, 32'h0, 0, 4'b0000, 2'b00, 0, 0, 1));
    vecs.push_back(mk("cont_after", 0, 2'b00, 32'h300, 32'h17, 16, 4'b1010, 2'b01, 1,
                      32'h300, 32'h17, 16, 4'b1010, 2'b01, 1, 1, 0));

    // Reset with every input at all-ones for two cycles.
    @(negedge clk);
    rst = 1'b1; ctrl = pipeline_control'(2'b11);
    pc_d = '1; pc4_d = '1; rd1_d = '1; rd2_d = '1; imm_d = '1;
    rs1_d = '1; rs2_d = '1; rd_d = '1; rw_d = 1; mw_d = 1; jmp_d = 1; br_d = 1;
    asrc_d = 1; rs_d = '1; alu_d = '1; v_d = 1;
    tick();
    tick();
    chk("rst.data", pc_e | pc4_e | rd1_e | rd2_e | imm_e, 32'd0);
    chk("rst.addr", 32'({rs1_e, rs2_e, rd_e, alu_e, rs_e}), 32'd0);
    chk("rst.ctrl", 32'({rw_e, mw_e, jmp_e, br_e, asrc_e, v_e, load_e}), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      tick();
      check_vec(vecs[i]);
    end

    // Outputs must not follow inputs between clock edges.
    @(negedge clk);
    pc_d = 32'hABCD; rd1_d = 32'h4321; v_d = 0;
    #2;
    chk("no_comb.pc", pc_e, 32'h300);
    chk("no_comb.valid", 32'(v_e), 32'd1);

`ifdef PIPE_PERF_COUNTERS_EN
    @(negedge clk);
    rst = 1'b1; ctrl = CONTINUE; v_d = 1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ctrl = (i < 4) ? CONTINUE : ((i < 6) ? STALL : FLUSH);
      tick();
      @(negedge clk);
    end
    chk("perf.issue", issue_cnt, 32'd4);
    chk("perf.stall", stall_cnt, 32'd2);
    chk("perf.flush", flush_cnt, 32'd1);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    ctrl = STALL;
    for (int i = 0; i < 3; i++) tick();
    chk("perf.stall_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Decode→execute pipeline register of the 5-stage RV32I core.
- Consumes the `pipeline_control` command (CONTINUE/STALL/FLUSH) issued by the hazard unit for the execute stage.
- Captures, holds or bubbles all decode-stage operands and control fields.
- Exports the execute-stage register addresses and load flag back to the hazard unit for forwarding and load-use detection.

Parameters:
- DATA_WIDTH, 32, width of register operands, PC and immediate.
- ADDR_WIDTH, 5, register-file address width.
- ALU_CTRL_WIDTH, 4, width of ALU operation select.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- control_i  in  pipeline_control  command from hazard unit: CONTINUE, STALL or FLUSH.
- pc_d_i  in  DATA_WIDTH  decode-stage PC.
- pc_plus4_d_i  in  DATA_WIDTH  decode-stage PC+4.
- rd1_d_i / rd2_d_i  in  DATA_WIDTH each  register-file read data.
- imm_d_i  in  DATA_WIDTH  extended immediate.
- rs1_d_i / rs2_d_i / rd_d_i  in  ADDR_WIDTH each  source and destination addresses.
- reg_write_d_i, mem_write_d_i, jump_d_i, branch_d_i, alu_src_d_i  in  1 each  decoded controls.
- result_src_d_i  in  2  result select: 00 ALU, 01 memory, 10 PC+4.
- alu_control_d_i  in  ALU_CTRL_WIDTH  ALU operation.
- valid_d_i  in  1  decode slot holds a real instruction.
- Outputs: one `*_e_o` counterpart per `*_d_i` input, same width, registered.
- is_load_e_o  out  1  registered, equals (result_src_e_o == 01) & valid_e_o; feeds hazard-unit load-use check.

Behaviour:
- All outputs registered, one-cycle latency; no combinational path from inputs to outputs.
- Reset (rst_i=1 at a clock edge): every output is 0, including valid_e_o and is_load_e_o. Reset overrides control_i.
- CONTINUE: all fields captured from the `*_d_i` inputs.
- STALL: all fields hold their current values, including valid.
- FLUSH: inserts a bubble.
  - valid, reg_write, mem_write, jump, branch are cleared to 0.
  - result_src and alu_control are set to 0.
  - rs1, rs2 and rd are set to 0, so forwarding never matches x0.
  - Data fields (pc, rd1, rd2, imm) are don't-care; the implementation zeroes them for determinism.
- Bubble rule: a bubble never writes registers or memory, never redirects the PC, and never asserts is_load.
- Unencoded control_i value: treated as FLUSH (fail-safe).
- Simultaneous events: reset > FLUSH > STALL > CONTINUE.
- Invalid input slot: valid_d_i=0 under CONTINUE is captured as a bubble. Side-effect controls are masked to 0 at capture, so downstream stages need not check valid.
- Reset mid-stall: the next cycle after reset deasserts, the register is empty and obeys control_i normally.

Optional Feature:
- Macro: PIPE_PERF_COUNTERS_EN.
- Defined: adds three 32-bit outputs, all saturating at 0xFFFF_FFFF and cleared by rst_i.
  - stall_cnt_o: cycles with STALL.
  - flush_cnt_o: cycles with FLUSH.
  - issue_cnt_o: CONTINUE cycles with valid_d_i=1.
- Not defined: counters and ports absent; the datapath is functionally identical.

Decomposition:
- Shared package `pipeline_pkg`:
  - `pipeline_control` enum {CONTINUE, STALL, FLUSH}, 2-bit.
  - result_src encodings (RES_ALU, RES_MEM, RES_PC4).
  - Packed struct `de_ctrl_t` bundling the decoded control fields, with constant `DE_CTRL_BUBBLE` (all zero).
- Sub-module `pipe_stage_reg`, parameterised by WIDTH and BUBBLE_VALUE.
  - Generic capture/hold/bubble register driven by pipeline_control with synchronous reset.
  - Instantiated for the control struct and the data bundle.
  - Reused later by the fetch/decode and execute/memory registers.

Test Plan:
- Reset: rst_i=1 with all inputs at 1s for 2 cycles → every output 0; then CONTINUE with pc_d_i=0x100 → pc_e_o=0x100 one cycle later.
- Stall: capture rd1_d_i=0xDEAD_BEEF, then STALL for 3 cycles with rd1_d_i changed to 0x1234 → rd1_e_o stays 0xDEAD_BEEF; CONTINUE → 0x1234 next cycle.
- Flush: capture reg_write=1, rd=5, result_src=01, then FLUSH → reg_write_e_o=0, rd_e_o=0, is_load_e_o=0, valid_e_o=0.
- Load flag: CONTINUE with result_src_d_i=01, valid=1 → is_load_e_o=1; same fields with valid_d_i=0 → is_load_e_o=0, mem_write_e_o=0.
- Priority: rst_i=1 together with CONTINUE → outputs 0; illegal control_i=2'b11 → bubble as in FLUSH.
- With PIPE_PERF_COUNTERS_EN: sequence of 4 CONTINUE(valid), 2 STALL, 1 FLUSH → issue=4, stall=2, flush=1; counter forced to 0xFFFF_FFFE plus 3 stalls → 0xFFFF_FFFF.
